seq_shifter: RTL and testbench

Multi-cycle, parametrised shift unit with valid/ready handshakes on input and output. Supports logical right, logical left, arithmetic right, and (optionally) rotate right. It shifts one bit position per clock, trading latency for area. It sits beside the combinational ALU datapath for multi-cycle operations.

---
 rtl/seq_shifter.sv | 110 +++++++++++
 tb/tb_seq_shifter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Sequential shift unit: SRL/SLL/SRA (and ROR when SEQ_SHIFTER_ROTATE_EN is
// defined) moving one bit position per clock, with valid/ready on both sides.
module seq_shifter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         busy
);

    localparam int LW = $clog2(N);
    localparam int CW = LW + 1;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    work_reg;
    logic [N-1:0]    out_reg;
    logic [1:0]      op_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   eff_next;
    logic [N-1:0]    step_next;

    // Amounts past the width saturate at N, so fills complete and stop there.
    always_comb begin
        eff_next = (b >= N'(N)) ? CW'(N) : b[CW-1:0];
`ifdef SEQ_SHIFTER_ROTATE_EN
        if (op == OP_ROR) begin
            eff_next = {1'b0, b[LW-1:0]};
        end
`endif
    end

    // SRA keeps work_reg[N-1] fixed, so it always equals the original sign.
    always_comb begin
        case (op_reg)
            OP_SLL:  step_next = {work_reg[N-2:0], 1'b0};
            OP_SRA:  step_next = {work_reg[N-1], work_reg[N-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            OP_ROR:  step_next = {work_reg[0], work_reg[N-1:1]};
`endif
            default: step_next = {1'b0, work_reg[N-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            op_reg    <= OP_SRL;
            count_reg <= '0;
            out_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        work_reg  <= a;
                        op_reg    <= op;
                        count_reg <= eff_next;
                        if (eff_next == '0) begin
                            out_reg   <= a;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_reg  <= step_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        out_reg   <= step_next;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out       = out_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and random checks of seq_shifter (N = 8) against an arithmetic
// reference model; rotate expectations follow SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

    localparam int N = 8;
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    seq_shifter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int ref_eff(input logic [7:0] bv, input logic [1:0] opv);
        if (ROT && opv == 2'b11) return int'(bv) % N;
        return (int'(bv) > N) ? N : int'(bv);
    endfunction

    function automatic logic [7:0] ref_out(input logic [7:0] av, input logic [7:0] bv,
                                           input logic [1:0] opv);
        int e;
        logic [7:0] lo, hi;
        e = ref_eff(bv, opv);
        case (opv)
            2'b01: return av << e;
            2'b10: return $unsigned($signed(av) >>> e);
            2'b11: begin
                if (!ROT) return av >> e;
                lo = av >> e;
                hi = (e == 0) ? 8'h00 : (av << (N - e));
                return lo | hi;
            end
            default: return av >> e;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request once in_ready is seen and returns just after the accept edge.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] opv);
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        chk("in_ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        op = opv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk("done_within_budget", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake(input logic [7:0] expv);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("out_hold", 32'(out), 32'(expv));
    endtask

    task automatic txn(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] opv,
                       input int stall);
        int lat;
        bit bok;
        logic [7:0] expv;
        expv = ref_out(av, bv, opv);
        send(av, bv, opv);
        wait_done(lat, bok);
        chk("result", 32'(out), 32'(expv));
        chk("latency", 32'(lat), 32'(ref_eff(bv, opv) + 1));
        chk("busy_during_shift", 32'(bok), 32'd1);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out", 32'(out), 32'(expv));
        end
        handshake(expv);
        $display("txn op=%0d a=%02h b=%0d -> out=%02h exp=%02h lat=%0d", opv, av, bv, out, expv, lat);
    endtask

    logic [7:0] bq_a [3] = '{8'hB4, 8'h81, 8'h5A};
    logic [7:0] bq_b [3] = '{8'd3, 8'd1, 8'd0};
    logic [1:0] bq_op[3] = '{2'b00, 2'b01, 2'b10};

    initial begin
        int lat;
        bit bok;
        int acc_cyc [3];
        int idx, got;
        bit acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Basic shifts and boundary amounts
        txn(8'hB4, 8'd3,   2'b00, 0);
        txn(8'h81, 8'd1,   2'b01, 0);
        txn(8'h90, 8'd2,   2'b10, 0);
        txn(8'h5A, 8'd0,   2'b00, 0);
        txn(8'hFF, 8'd200, 2'b00, 0);
        txn(8'h80, 8'd200, 2'b10, 0);
        txn(8'h81, 8'd200, 2'b01, 0);
        txn(8'h81, 8'd9,   2'b11, 0);
        txn(8'h81, 8'd0,   2'b11, 0);

        // Backpressure with a competing request held during DONE
        send(8'h3C, 8'd2, 2'b00);
        wait_done(lat, bok);
        in_valid = 1'b1;
        a = 8'hA5;
        b = 8'd1;
        op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out", 32'(out), 32'h0F);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_accepted_busy", 32'(busy), 32'd1);
        wait_done(lat, bok);
        chk("bp_second_result", 32'(out), 32'h4A);
        chk("bp_second_latency", 32'(lat), 32'd2);
        handshake(8'h4A);
        $display("txn backpressure: second result out=%02h lat=%0d", out, lat);

        // Reset during the third SHIFT cycle
        send(8'hF0, 8'd6, 2'b00);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        $display("txn reset mid-shift: out=%02h busy=%0d", out, busy);
        txn(8'hF0, 8'd6, 2'b00, 0);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = bq_a[0];
        b = bq_b[0];
        op = bq_op[0];
        idx = 0;
        got = 0;
        for (int c = 0; c < 100 && got < 3; c++) begin
            if (out_valid) begin
                chk("b2b_result", 32'(out), 32'(ref_out(bq_a[got], bq_b[got], bq_op[got])));
                $display("txn b2b #%0d out=%02h", got, out);
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    a = bq_a[idx];
                    b = bq_b[idx];
                    op = bq_op[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", 32'(got), 32'd3);
        for (int i = 0; i < 2; i++) begin
            chk("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(ref_eff(bq_b[i], bq_op[i]) + 2));
        end
        out_ready = 1'b0;
        tick();

        // Random requests with random output stalls
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic [1:0] rop;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 11));
            rop = 2'($urandom_range(0, 3));
            txn(ra, rb, rop, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
